// File: rtl/serial_frame_receiver.sv
// serial_frame_receiver: strobed serial-in to WIDTH-bit word with valid/ready hold reg and sticky overrun; ports cp/cr_ clock/async-low reset, start/sen/sin/dir frame input, rdy/clr_ovr consumer controls, Q/vld/busy/ovr/cnt status
module serial_frame_receiver #(
  parameter int WIDTH = 8,
  parameter int CW = $clog2(WIDTH + 1)
) (
  input  logic             cp,
  input  logic             cr_,
  input  logic             start,
  input  logic             sen,
  input  logic             sin,
  input  logic             dir,
  input  logic             rdy,
  input  logic             clr_ovr,
  output logic [WIDTH-1:0] Q,
  output logic             vld,
  output logic             busy,
  output logic             ovr,
  output logic [CW-1:0]    cnt
);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] sreg, sreg_n, shifted, q_n;
  logic [CW-1:0] cnt_n;
  logic dir_q, dir_n, vld_n, ovr_n, shift, done, load;
  always_comb begin
    shifted = dir_q ? {sreg[WIDTH-2:0], sin} : {sin, sreg[WIDTH-1:1]};
    shift = state == SHIFT && sen && !start;
    done = shift && cnt == CW'(WIDTH - 1);
    load = done && (!vld || rdy);
    state_n = start ? SHIFT : done ? IDLE : state;
    sreg_n = start ? '0 : shift ? shifted : sreg;
    cnt_n = (start || done) ? '0 : shift ? cnt + CW'(1) : cnt;
    dir_n = start ? dir : dir_q;
    q_n = load ? shifted : Q;
    vld_n = load || (vld && !rdy);
    ovr_n = (done && vld && !rdy) || (ovr && !clr_ovr);
  end
  always_ff @(posedge cp or negedge cr_)
    if (!cr_) begin
      state <= IDLE;
      sreg <= '0;
      cnt <= '0;
      dir_q <= 1'b0;
      Q <= '0;
      vld <= 1'b0;
      ovr <= 1'b0;
    end else begin
      state <= state_n;
      sreg <= sreg_n;
      cnt <= cnt_n;
      dir_q <= dir_n;
      Q <= q_n;
      vld <= vld_n;
      ovr <= ovr_n;
    end
  assign busy = state == SHIFT;
endmodule

// File: tb/tb_serial_frame_receiver.sv
// tb_serial_frame_receiver: directed and random stimulus checked against a frame-level reference model
module tb_serial_frame_receiver;
  localparam int W = 8;
  localparam int CW = $clog2(W + 1);
  logic cp = 0, cr_ = 0, start = 0, sen = 0, sin = 0, dir = 0, rdy = 0, clr_ovr = 0;
  logic [W-1:0] q;
  logic vld, busy, ovr;
  logic [CW-1:0] cnt;
  int checks = 0, errors = 0;
  bit mbits[$];
  bit in_frame = 0, mdir = 0, mvld = 0, movr = 0;
  logic [W-1:0] mq = '0;
  serial_frame_receiver #(.WIDTH(W)) dut (
    .cp(cp), .cr_(cr_), .start(start), .sen(sen), .sin(sin), .dir(dir), .rdy(rdy),
    .clr_ovr(clr_ovr), .Q(q), .vld(vld), .busy(busy), .ovr(ovr), .cnt(cnt)
  );
  always #5 cp = ~cp;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_model(input string tag);
    chk({tag, "_q"}, 32'(q), 32'(mq));
    chk({tag, "_vld"}, 32'(vld), 32'(mvld));
    chk({tag, "_busy"}, 32'(busy), 32'(in_frame));
    chk({tag, "_ovr"}, 32'(ovr), 32'(movr));
    chk({tag, "_cnt"}, 32'(cnt), in_frame ? 32'(mbits.size()) : 32'd0);
  endtask
  task automatic model_reset();
    mbits.delete();
    in_frame = 0; mdir = 0; mvld = 0; movr = 0; mq = '0;
  endtask
  // One clock: drive inputs, advance the frame-level model, check all outputs after the edge.
  task automatic step(input bit st, input bit se, input bit si, input bit d, input bit r, input bit c);
    bit done;
    logic [W-1:0] w;
    start = st; sen = se; sin = si; dir = d; rdy = r; clr_ovr = c;
    done = 0; w = '0;
    if (st) begin
      in_frame = 1; mdir = d; mbits.delete();
    end else if (in_frame && se) begin
      mbits.push_back(si);
      if (mbits.size() == W) begin
        for (int i = 0; i < W; i++)
          if (mbits[i]) w = w | (mdir ? (W'(1) << (W - 1 - i)) : (W'(1) << i));
        done = 1; in_frame = 0; mbits.delete();
      end
    end
    movr = (done && mvld && !r) || (movr && !c);
    if (done && (!mvld || r)) begin
      mq = w; mvld = 1;
    end else if (mvld && r) mvld = 0;
    @(posedge cp);
    #1;
    chk_model("step");
  endtask
  // Stream a word in the order its dir calls for; rdy is raised only with the final bit if asked.
  task automatic send(input logic [W-1:0] wd, input bit d, input bit do_start, input int gap, input bit last_rdy);
    if (do_start) step(1, 0, 0, d, 0, 0);
    for (int i = 0; i < W; i++) begin
      for (int g = 0; g < gap; g++) step(0, 0, 1, ~d, 0, 0);
      step(0, 1, d ? wd[W-1-i] : wd[i], ~d, (i == W - 1) ? last_rdy : 1'b0, 0);
    end
  endtask
  initial begin
    #12;
    chk("por_q", 32'(q), 0);
    chk("por_vld", 32'(vld), 0);
    cr_ = 1;
    @(posedge cp); #1;
    // Reset mid-frame clears everything immediately.
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    chk("pre_rst_cnt", 32'(cnt), 3);
    #2 cr_ = 0;
    #1;
    model_reset();
    chk("rst_q", 32'(q), 0);
    chk("rst_vld", 32'(vld), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cnt", 32'(cnt), 0);
    chk("rst_ovr", 32'(ovr), 0);
    @(posedge cp); #1;
    cr_ = 1;
    step(0, 1, 1, 0, 0, 0);
    chk("idle_sen_ignored", 32'(cnt), 0);
    // LSB-first 0xA5 with rdy low.
    send(8'hA5, 0, 1, 0, 0);
    chk("lsb_q", 32'(q), 32'hA5);
    chk("lsb_vld", 32'(vld), 1);
    chk("lsb_busy", 32'(busy), 0);
    // Overrun: 0x3C arrives while 0xA5 is unconsumed.
    send(8'h3C, 0, 1, 0, 0);
    chk("ovr_q", 32'(q), 32'hA5);
    chk("ovr_flag", 32'(ovr), 1);
    step(0, 0, 0, 0, 0, 1);
    chk("ovr_clr", 32'(ovr), 0);
    step(0, 0, 0, 0, 1, 0);
    chk("take_vld", 32'(vld), 0);
    // MSB-first with idle gaps.
    send(8'hAA, 1, 1, 2, 0);
    chk("msb_q", 32'(q), 32'hAA);
    chk("msb_vld", 32'(vld), 1);
    step(0, 0, 0, 0, 1, 0);
    chk("msb_take", 32'(vld), 0);
    // Restart: 3 bits, then start together with sen, then 0x55.
    step(1, 0, 0, 1, 0, 0);
    step(0, 1, 1, 1, 0, 0);
    step(0, 1, 1, 1, 0, 0);
    step(0, 1, 1, 1, 0, 0);
    step(1, 1, 1, 0, 0, 0);
    chk("restart_cnt", 32'(cnt), 0);
    send(8'h55, 0, 0, 0, 0);
    chk("restart_q", 32'(q), 32'h55);
    chk("restart_ovr", 32'(ovr), 0);
    step(0, 0, 0, 0, 1, 0);
    // Back-to-back: second word completes on the cycle the first is taken.
    send(8'h0F, 0, 1, 0, 0);
    chk("b2b_q1", 32'(q), 32'h0F);
    send(8'hF0, 0, 1, 0, 1);
    chk("b2b_vld", 32'(vld), 1);
    chk("b2b_q2", 32'(q), 32'hF0);
    chk("b2b_ovr", 32'(ovr), 0);
    // Overrun and clr_ovr together keep ovr set.
    send(8'h81, 1, 1, 0, 0);
    step(1, 0, 0, 1, 0, 0);
    for (int i = 0; i < W - 1; i++) step(0, 1, 1, 1, 0, 0);
    step(0, 1, 0, 1, 0, 1);
    chk("ovr_vs_clr", 32'(ovr), 1);
    chk("ovr_vs_clr_q", 32'(q), 32'hF0);
    step(0, 0, 0, 0, 1, 1);
    // Random traffic.
    for (int n = 0; n < 600; n++)
      step($urandom_range(0, 19) == 0, $urandom_range(0, 2) != 0, 1'($urandom), 1'($urandom),
           $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
